axil_ocl_fabric: RTL and testbench
==================================

Name: axil_ocl_fabric

Overview:
- Parametrised AXI-Lite (OCL BAR0) slave front-end for the CL. It replaces the single-target, fixed-latency read/write glue in front of the Ising array.
- Decodes the incoming address into NUM_TGT equal regions and drives a simple req/ack register port per target. Targets may have variable latency.
- Adds independent write-address/write-data acceptance, DECERR for unmapped addresses, SLVERR on per-access timeout, and a saturating error counter.
- Sits between the AXI-Lite register slice and the Ising core plus future status/config targets.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- NUM_TGT, 4, number of target regions (1..16).
- REGION_BITS, 12, log2 of region size in bytes; region offset = addr[REGION_BITS-1:0].
- TIMEOUT_CYCLES, 256, cycles a req may stay pending before forced SLVERR (>=2).

Ports:
- clk_main_a0  in  1  clock
- rst_main_n  in  1  asynchronous, active-low reset
- s_awvalid/s_awready  in/out  1  write address handshake
- s_awaddr  in  ADDR_W  write address
- s_wvalid/s_wready  in/out  1  write data handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_bvalid/s_bready  out/in  1  write response handshake
- s_bresp  out  2  write response
- s_arvalid/s_arready  in/out  1  read address handshake
- s_araddr  in  ADDR_W  read address
- s_rvalid/s_rready  out/in  1  read data handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- t_wr_req  out  NUM_TGT  one-hot write request, level
- t_wr_addr  out  REGION_BITS  write offset
- t_wr_data  out  32  write data
- t_wr_strb  out  4  write strobes
- t_wr_ack  in  NUM_TGT  one-cycle write acknowledge
- t_rd_req  out  NUM_TGT  one-hot read request, level
- t_rd_addr  out  REGION_BITS  read offset
- t_rd_ack  in  NUM_TGT  one-cycle read acknowledge
- t_rd_data  in  NUM_TGT*32  read data per target, valid with its ack
- err_cnt  out  16  saturating count of non-OKAY responses

Behaviour:
Reset and decode:
- Reset clk_main_a0 / rst_main_n, asynchronous, active-low.
- Reset forces: all req low, bvalid/rvalid low, resp/rdata 0, err_cnt 0, both FSMs idle. A reset mid-access drops req immediately; no response is issued.
- Decode: idx = addr >> REGION_BITS. If idx >= NUM_TGT the access is DECERR; no req is raised.
- Response codes: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.

Write FSM (WR_IDLE, WR_REQ, WR_RESP):
- In WR_IDLE: s_awready = !aw_held; s_wready = !w_held. AW and W may arrive in either order or in the same cycle. Each is captured on its handshake.
- Once both are held, the next state is WR_REQ, or WR_RESP with DECERR if unmapped.
- WR_REQ: t_wr_req[idx] is high; addr/data/strb are stable.
  - Ack -> WR_RESP OKAY; req drops the next cycle.
  - Timeout counter reaches TIMEOUT_CYCLES-1 without ack -> WR_RESP SLVERR.
  - Ack in the timeout cycle: ack wins (OKAY).
  - A late ack after timeout is ignored.
- WR_RESP: s_bvalid is held with a stable bresp until s_bready, then WR_IDLE; held flags are cleared.
- Latency: AW+W at cycle T -> req at T+1; ack at T+1 -> bvalid at T+2.

Read FSM (RD_IDLE, RD_REQ, RD_RESP):
- s_arready = (state==RD_IDLE). Acceptance at T -> RD_REQ at T+1, or RD_RESP at T+1 with DECERR and rdata 0.
- On t_rd_ack[idx], rdata is captured from that target's slice; rvalid follows the next cycle with OKAY.
- Timeout -> SLVERR, rdata 32'hDEAD_BEEF.
- rvalid, rdata and rresp are stable until s_rready.
- Read and write paths are fully independent and may target the same region concurrently; ordering between them is not guaranteed.

Error counter:
- err_cnt increments once per non-OKAY response, counted at its handshake (bvalid&bready or rvalid&rready).
- Both paths in the same cycle -> +2.
- Saturates at 16'hFFFF.

Decomposition:
- Package axil_ocl_pkg: resp code constants, wr_state_e/rd_state_e enums, TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module axil_ocl_decode: combinational addr -> idx / one-hot / valid. It is instantiated once per path.
- Timeout counters are inline, one per path, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Write 0x0000_1008 data 0xCAFE_0001 strb 0xF, AW and W same cycle, target 1 acks after 3 cycles -> t_wr_req=4'b0010, t_wr_addr=0x008, bresp OKAY, bvalid 1 cycle after ack.
- W presented 5 cycles before AW, then AW to 0x0000_0004 -> no req until AW; req on target 0 with held data; s_wready low while data is held.
- Read 0x0000_4000 (NUM_TGT=4) -> no t_rd_req, rvalid at T+1, rresp DECERR, rdata 0, err_cnt=1.
- Read target 2 with no ack -> req held 256 cycles, then rresp SLVERR, rdata 0xDEAD_BEEF; an ack at cycle 300 is ignored; err_cnt increments.
- Read target 3 (ack data 0x1234_5678) while a write to target 3 is pending; hold s_rready low 4 cycles -> rdata stable at 0x1234_5678, write completes independently.
- Assert rst_main_n low while t_rd_req is high -> req, rvalid and err_cnt go to 0 asynchronously; a new read after release completes normally.

Source files
------------

// File: rtl/axil_ocl_pkg.sv
// Shared constants and state types for the OCL BAR0 AXI-Lite fabric.
package axil_ocl_pkg;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [1:0]  RESP_DECERR   = 2'b11;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_REQ  = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

  // Add 0..2 error events to the counter, clamping at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/axil_ocl_decode.sv
// Combinational address decode into NUM_TGT equal regions of 2**REGION_BITS bytes.
module axil_ocl_decode #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_TGT     = 4,
  parameter int unsigned REGION_BITS = 12,
  parameter int unsigned IDX_W       = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [IDX_W-1:0]   o_idx,
  output logic [NUM_TGT-1:0] o_onehot,
  output logic               o_valid
);

  logic [ADDR_W-1:0] w_region;

  always_comb begin
    w_region = i_addr >> REGION_BITS;
    o_valid  = (w_region < ADDR_W'(NUM_TGT));
    o_idx    = w_region[IDX_W-1:0];
    o_onehot = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      o_onehot[i] = o_valid && (w_region == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/axil_ocl_fabric.sv
// AXI-Lite slave front-end fanning out to NUM_TGT req/ack register targets, with
// independent read/write paths, DECERR/SLVERR reporting and a saturating error counter.
module axil_ocl_fabric
  import axil_ocl_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned NUM_TGT        = 4,
  parameter int unsigned REGION_BITS    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_main_a0,
  input  logic                    rst_main_n,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_W-1:0]       s_araddr,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic [NUM_TGT-1:0]      t_wr_req,
  output logic [REGION_BITS-1:0]  t_wr_addr,
  output logic [31:0]             t_wr_data,
  output logic [3:0]              t_wr_strb,
  input  logic [NUM_TGT-1:0]      t_wr_ack,
  output logic [NUM_TGT-1:0]      t_rd_req,
  output logic [REGION_BITS-1:0]  t_rd_addr,
  input  logic [NUM_TGT-1:0]      t_rd_ack,
  input  logic [NUM_TGT*32-1:0]   t_rd_data,
  output logic [15:0]             err_cnt
);

  localparam int unsigned IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // ---------------- write path ----------------
  wr_state_e          r_wr_state, w_wr_state_nxt;
  logic               r_aw_held, w_aw_held_nxt;
  logic               r_w_held, w_w_held_nxt;
  logic [TO_W-1:0]    r_wr_cnt, w_wr_cnt_nxt;
  logic [1:0]         r_bresp, w_bresp_nxt;
  logic [ADDR_W-1:0]  r_awaddr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;

  logic               w_aw_hs, w_w_hs;
  logic [ADDR_W-1:0]  w_wr_addr_sel;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [NUM_TGT-1:0] w_wr_onehot;
  logic               w_wr_valid;
  logic               w_wr_ack;

  assign s_awready = (r_wr_state == WR_IDLE) && !r_aw_held;
  assign s_wready  = (r_wr_state == WR_IDLE) && !r_w_held;
  assign w_aw_hs   = s_awvalid && s_awready;
  assign w_w_hs    = s_wvalid && s_wready;

  // Decode the live address on the cycle it arrives so the req can rise next cycle.
  assign w_wr_addr_sel = w_aw_hs ? s_awaddr : r_awaddr;

  axil_ocl_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_TGT     (NUM_TGT),
    .REGION_BITS (REGION_BITS),
    .IDX_W       (IDX_W)
  ) u_wr_decode (
    .i_addr   (w_wr_addr_sel),
    .o_idx    (w_wr_idx),
    .o_onehot (w_wr_onehot),
    .o_valid  (w_wr_valid)
  );

  assign w_wr_ack = t_wr_ack[w_wr_idx];

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_aw_held_nxt  = r_aw_held;
    w_w_held_nxt   = r_w_held;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_bresp_nxt    = r_bresp;
    unique case (r_wr_state)
      WR_IDLE: begin
        w_wr_cnt_nxt = '0;
        if (w_aw_hs) w_aw_held_nxt = 1'b1;
        if (w_w_hs)  w_w_held_nxt  = 1'b1;
        if (w_aw_held_nxt && w_w_held_nxt) begin
          if (w_wr_valid) begin
            w_wr_state_nxt = WR_REQ;
          end else begin
            w_wr_state_nxt = WR_RESP;
            w_bresp_nxt    = RESP_DECERR;
          end
        end
      end
      WR_REQ: begin
        if (w_wr_ack) begin
          w_wr_state_nxt = WR_RESP;
          w_bresp_nxt    = RESP_OKAY;
        end else if (r_wr_cnt == TO_LAST) begin
          w_wr_state_nxt = WR_RESP;
          w_bresp_nxt    = RESP_SLVERR;
        end else begin
          w_wr_cnt_nxt = r_wr_cnt + 1'b1;
        end
      end
      WR_RESP: begin
        if (s_bready) begin
          w_wr_state_nxt = WR_IDLE;
          w_aw_held_nxt  = 1'b0;
          w_w_held_nxt   = 1'b0;
        end
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_wr_state <= WR_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_wr_cnt   <= '0;
      r_bresp    <= RESP_OKAY;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_aw_held  <= w_aw_held_nxt;
      r_w_held   <= w_w_held_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_bresp    <= w_bresp_nxt;
      if (w_aw_hs) r_awaddr <= s_awaddr;
      if (w_w_hs) begin
        r_wdata <= s_wdata;
        r_wstrb <= s_wstrb;
      end
    end
  end

  assign t_wr_req  = (r_wr_state == WR_REQ) ? w_wr_onehot : '0;
  assign t_wr_addr = r_awaddr[REGION_BITS-1:0];
  assign t_wr_data = r_wdata;
  assign t_wr_strb = r_wstrb;
  assign s_bvalid  = (r_wr_state == WR_RESP);
  assign s_bresp   = r_bresp;

  // ---------------- read path ----------------
  rd_state_e          r_rd_state, w_rd_state_nxt;
  logic [TO_W-1:0]    r_rd_cnt, w_rd_cnt_nxt;
  logic [1:0]         r_rresp, w_rresp_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic [ADDR_W-1:0]  r_araddr;

  logic               w_ar_hs;
  logic [ADDR_W-1:0]  w_rd_addr_sel;
  logic [IDX_W-1:0]   w_rd_idx;
  logic [NUM_TGT-1:0] w_rd_onehot;
  logic               w_rd_valid;
  logic               w_rd_ack;
  logic [31:0]        w_rd_slice;

  assign s_arready     = (r_rd_state == RD_IDLE);
  assign w_ar_hs       = s_arvalid && s_arready;
  assign w_rd_addr_sel = (r_rd_state == RD_IDLE) ? s_araddr : r_araddr;

  axil_ocl_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_TGT     (NUM_TGT),
    .REGION_BITS (REGION_BITS),
    .IDX_W       (IDX_W)
  ) u_rd_decode (
    .i_addr   (w_rd_addr_sel),
    .o_idx    (w_rd_idx),
    .o_onehot (w_rd_onehot),
    .o_valid  (w_rd_valid)
  );

  assign w_rd_ack = t_rd_ack[w_rd_idx];

  always_comb begin
    w_rd_slice = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (w_rd_onehot[i]) w_rd_slice = t_rd_data[i*32 +: 32];
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rresp_nxt    = r_rresp;
    w_rdata_nxt    = r_rdata;
    unique case (r_rd_state)
      RD_IDLE: begin
        w_rd_cnt_nxt = '0;
        if (w_ar_hs) begin
          if (w_rd_valid) begin
            w_rd_state_nxt = RD_REQ;
          end else begin
            w_rd_state_nxt = RD_RESP;
            w_rresp_nxt    = RESP_DECERR;
            w_rdata_nxt    = '0;
          end
        end
      end
      RD_REQ: begin
        if (w_rd_ack) begin
          w_rd_state_nxt = RD_RESP;
          w_rresp_nxt    = RESP_OKAY;
          w_rdata_nxt    = w_rd_slice;
        end else if (r_rd_cnt == TO_LAST) begin
          w_rd_state_nxt = RD_RESP;
          w_rresp_nxt    = RESP_SLVERR;
          w_rdata_nxt    = TIMEOUT_RDATA;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + 1'b1;
        end
      end
      RD_RESP: begin
        if (s_rready) w_rd_state_nxt = RD_IDLE;
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_araddr   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rresp    <= w_rresp_nxt;
      r_rdata    <= w_rdata_nxt;
      if (w_ar_hs) r_araddr <= s_araddr;
    end
  end

  assign t_rd_req  = (r_rd_state == RD_REQ) ? w_rd_onehot : '0;
  assign t_rd_addr = r_araddr[REGION_BITS-1:0];
  assign s_rvalid  = (r_rd_state == RD_RESP);
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;

  // ---------------- error counter ----------------
  logic        w_b_err, w_r_err;
  logic [15:0] r_err_cnt;

  assign w_b_err = s_bvalid && s_bready && (r_bresp != RESP_OKAY);
  assign w_r_err = s_rvalid && s_rready && (r_rresp != RESP_OKAY);

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_err_cnt <= '0;
    end else if (w_b_err || w_r_err) begin
      r_err_cnt <= sat_add16(r_err_cnt, {1'b0, w_b_err} + {1'b0, w_r_err});
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_axil_ocl_fabric.sv
// Directed bench for axil_ocl_fabric: decode, handshake ordering, errors, timeout, reset.
module tb_axil_ocl_fabric;

  localparam int unsigned NT = 4;

  logic          clk_main_a0 = 1'b0;
  logic          rst_main_n  = 1'b0;
  logic          s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [31:0]   s_awaddr = '0, s_araddr = '0, s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic [1:0]    s_bresp, s_rresp;
  logic [31:0]   s_rdata;
  logic [NT-1:0] t_wr_req, t_rd_req;
  logic [NT-1:0] t_wr_ack = '0, t_rd_ack = '0;
  logic [11:0]   t_wr_addr, t_rd_addr;
  logic [31:0]   t_wr_data;
  logic [3:0]    t_wr_strb;
  logic [NT*32-1:0] t_rd_data = '0;
  logic [15:0]   err_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int n_req;

  axil_ocl_fabric #(
    .ADDR_W(32), .NUM_TGT(NT), .REGION_BITS(12), .TIMEOUT_CYCLES(256)
  ) dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .t_wr_req(t_wr_req), .t_wr_addr(t_wr_addr), .t_wr_data(t_wr_data),
    .t_wr_strb(t_wr_strb), .t_wr_ack(t_wr_ack),
    .t_rd_req(t_rd_req), .t_rd_addr(t_rd_addr), .t_rd_ack(t_rd_ack),
    .t_rd_data(t_rd_data), .err_cnt(err_cnt)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_wready",  32'(s_wready),  32'd1);
    chk("rst_arready", 32'(s_arready), 32'd1);
    chk("rst_valids",  {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("rst_reqs",    {24'd0, t_wr_req, t_rd_req}, 32'd0);
    chk("rst_err",     32'(err_cnt), 32'd0);
    rst_main_n = 1'b1;
    tick();

    // AW and W together to target 1, ack after 3 cycles.
    s_awvalid = 1; s_awaddr = 32'h0000_1008; s_wvalid = 1; s_wdata = 32'hCAFE_0001;
    s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("w1_req",  32'(t_wr_req), 32'h2);
    chk("w1_addr", 32'(t_wr_addr), 32'h008);
    chk("w1_data", t_wr_data, 32'hCAFE_0001);
    chk("w1_strb", 32'(t_wr_strb), 32'hF);
    tick(); tick();
    chk("w1_nobv", 32'(s_bvalid), 32'd0);
    t_wr_ack = 4'b0010;
    tick();
    t_wr_ack = '0;
    chk("w1_bvalid", 32'(s_bvalid), 32'd1);
    chk("w1_bresp",  32'(s_bresp), 32'd0);
    chk("w1_reqoff", 32'(t_wr_req), 32'd0);
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("w1_bdone", 32'(s_bvalid), 32'd0);

    // W five cycles before AW.
    s_wvalid = 1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'h3;
    tick();
    s_wvalid = 0;
    repeat (4) tick();
    chk("w2_wready", 32'(s_wready), 32'd0);
    chk("w2_noreq",  32'(t_wr_req), 32'd0);
    chk("w2_awready", 32'(s_awready), 32'd1);
    s_awvalid = 1; s_awaddr = 32'h0000_0004;
    tick();
    s_awvalid = 0;
    chk("w2_req",  32'(t_wr_req), 32'h1);
    chk("w2_addr", 32'(t_wr_addr), 32'h004);
    chk("w2_data", t_wr_data, 32'h5555_AAAA);
    chk("w2_strb", 32'(t_wr_strb), 32'h3);
    t_wr_ack = 4'b0001;
    tick();
    t_wr_ack = '0;
    chk("w2_bresp", {31'd0, s_bvalid} | {s_bresp, 2'b00, 28'd0}, 32'd1);
    s_bready = 1;
    tick();
    s_bready = 0;

    // Unmapped read.
    s_arvalid = 1; s_araddr = 32'h0000_4000;
    tick();
    s_arvalid = 0;
    chk("r3_noreq", 32'(t_rd_req), 32'd0);
    chk("r3_rvalid", 32'(s_rvalid), 32'd1);
    chk("r3_rresp", 32'(s_rresp), 32'h3);
    chk("r3_rdata", s_rdata, 32'd0);
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("r3_err", 32'(err_cnt), 32'd1);

    // Read timeout on target 2; late ack ignored.
    s_arvalid = 1; s_araddr = 32'h0000_2010;
    tick();
    s_arvalid = 0;
    n_req = 0;
    while (t_rd_req == 4'b0100 && n_req < 400) begin
      n_req++;
      tick();
    end
    chk("r4_reqlen", 32'(n_req), 32'd256);
    chk("r4_rvalid", 32'(s_rvalid), 32'd1);
    chk("r4_rresp",  32'(s_rresp), 32'h2);
    chk("r4_rdata",  s_rdata, 32'hDEAD_BEEF);
    repeat (44) tick();
    t_rd_data[2*32 +: 32] = 32'h1111_1111;
    t_rd_ack = 4'b0100;
    tick();
    t_rd_ack = '0;
    chk("r4_late_data", s_rdata, 32'hDEAD_BEEF);
    chk("r4_late_resp", 32'(s_rresp), 32'h2);
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("r4_err", 32'(err_cnt), 32'd2);

    // Read target 3 while a write to target 3 is pending; rready held off.
    s_awvalid = 1; s_awaddr = 32'h0000_3000; s_wvalid = 1; s_wdata = 32'h0BAD_F00D;
    s_wstrb = 4'hF;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    s_arvalid = 1; s_araddr = 32'h0000_3004;
    tick();
    s_arvalid = 0;
    chk("r5_rdreq",  32'(t_rd_req), 32'h8);
    chk("r5_rdaddr", 32'(t_rd_addr), 32'h004);
    chk("r5_wrreq",  32'(t_wr_req), 32'h8);
    t_rd_data[3*32 +: 32] = 32'h1234_5678;
    t_rd_ack = 4'b1000;
    tick();
    t_rd_ack = '0;
    t_rd_data[3*32 +: 32] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) t_wr_ack = 4'b1000;
      tick();
      t_wr_ack = '0;
      chk("r5_rvalid", 32'(s_rvalid), 32'd1);
      chk("r5_rdata",  s_rdata, 32'h1234_5678);
    end
    chk("r5_rresp",  32'(s_rresp), 32'd0);
    chk("r5_bvalid", 32'(s_bvalid), 32'd1);
    chk("r5_bresp",  32'(s_bresp), 32'd0);
    s_rready = 1; s_bready = 1;
    tick();
    s_rready = 0; s_bready = 0;
    chk("r5_done", {30'd0, s_bvalid, s_rvalid}, 32'd0);
    chk("r5_err",  32'(err_cnt), 32'd2);

    // Both paths DECERR in the same handshake cycle -> +2.
    s_awvalid = 1; s_awaddr = 32'h0000_5000; s_wvalid = 1;
    s_arvalid = 1; s_araddr = 32'h0000_6000;
    tick();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    chk("e6_bresp", 32'(s_bresp), 32'h3);
    chk("e6_rresp", 32'(s_rresp), 32'h3);
    chk("e6_noreq", {24'd0, t_wr_req, t_rd_req}, 32'd0);
    s_bready = 1; s_rready = 1;
    tick();
    s_bready = 0; s_rready = 0;
    chk("e6_err", 32'(err_cnt), 32'd4);

    // Ack arriving in the timeout cycle wins.
    s_awvalid = 1; s_awaddr = 32'h0000_0010; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    repeat (255) tick();
    chk("w7_req", 32'(t_wr_req), 32'h1);
    t_wr_ack = 4'b0001;
    tick();
    t_wr_ack = '0;
    chk("w7_bvalid", 32'(s_bvalid), 32'd1);
    chk("w7_bresp",  32'(s_bresp), 32'd0);
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("w7_err", 32'(err_cnt), 32'd4);

    // Asynchronous reset while a read req is pending.
    s_arvalid = 1; s_araddr = 32'h0000_1000;
    tick();
    s_arvalid = 0;
    chk("r8_req", 32'(t_rd_req), 32'h2);
    #2 rst_main_n = 1'b0;
    #1;
    chk("r8_rst_req", 32'(t_rd_req), 32'd0);
    chk("r8_rst_rv",  32'(s_rvalid), 32'd0);
    chk("r8_rst_err", 32'(err_cnt), 32'd0);
    tick();
    rst_main_n = 1'b1;
    tick();
    s_arvalid = 1; s_araddr = 32'h0000_1000;
    tick();
    s_arvalid = 0;
    t_rd_data[1*32 +: 32] = 32'hABCD_0123;
    t_rd_ack = 4'b0010;
    tick();
    t_rd_ack = '0;
    chk("r8_rvalid", 32'(s_rvalid), 32'd1);
    chk("r8_rdata",  s_rdata, 32'hABCD_0123);
    chk("r8_rresp",  32'(s_rresp), 32'd0);
    s_rready = 1;
    tick();
    s_rready = 0;
    chk("r8_err", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
